icb_add_master: RTL and testbench
=================================

// Module: icb_add_master
// PURPOSE
//  ICB initiator that drives the memory-mapped adder peripheral from the master side of the bus.
//  A local requester hands over two operands. The block runs the full register sequence over ICB:
//  load operands, enable, settle, read SUM and OFSIGN, then disable. It returns sum/overflow/error.
//  It sits between a local engine (or test harness) and the ICB fabric in front of the adder slave.
// PARAMETERS
//  BASE_ADDR   32'h1004_2000  byte base of adder peripheral; offsets fixed below
//  SETTLE_CYC  2              idle cycles after CTRL-enable write response, before SUM read (>=1)
//  TIMEOUT     64             max cycles waiting in RSP for icb_rsp_valid (>=2)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous active-low reset
//  req_valid      in   1   operand request valid
//  req_ready      out  1   block idle, accepts request
//  req_augend     in   32  augend operand
//  req_addend     in   32  addend operand
//  res_valid      out  1   result valid, held until res_ready
//  res_ready      in   1   result consumed
//  res_sum        out  32  SUM register value read back
//  res_ovf        out  1   OFSIGN[0] read back
//  res_err        out  1   1 = bus error or timeout; res_sum/res_ovf = 0
//  icb_cmd_valid  out  1   ICB command valid
//  icb_cmd_ready  in   1   ICB command accepted
//  icb_cmd_read   out  1   1 = read, 0 = write
//  icb_cmd_addr   out  32  BASE_ADDR + offset
//  icb_cmd_wdata  out  32  write data; 0 on reads
//  icb_cmd_wmask  out  4   4'hF on writes, 4'h0 on reads
//  icb_rsp_valid  in   1   ICB response valid
//  icb_rsp_ready  out  1   asserted only in RSP state
//  icb_rsp_rdata  in   32  read data
//  icb_rsp_err    in   1   response error
// BEHAVIOUR
//  Register map: +0x00 AUGEND, +0x04 ADDEND, +0x08 CTRL (bit0 enable, bit1 clear), +0x0C SUM, +0x10 OFSIGN.
//  Step sequence (3-bit step counter):
//   0 W AUGEND=augend
//   1 W ADDEND=addend
//   2 W CTRL=1
//   3 R SUM
//   4 R OFSIGN
//   5 W CTRL=0
//  FSM: IDLE -> CMD -> RSP -> (SETTLE after step 2 | CMD next step | DONE after step 5) ; DONE -> IDLE.
//  IDLE: req_ready=1. On req_valid&req_ready: latch both operands, step=0, go to CMD.
//  CMD: icb_cmd_valid=1 with fields of current step.
//   All cmd fields are registered and stable until icb_cmd_ready; then go to RSP.
//   Zero-wait slave: icb_cmd_valid&icb_cmd_ready completes in 1 cycle.
//  RSP: icb_rsp_ready=1; cmd_valid=0 (one outstanding transaction max). Timeout counter cleared on entry.
//   A response is never accepted in the same cycle as its command handshake.
//  Response capture: icb_rsp_rdata is captured to res_sum at step 3. Bit0 is captured to res_ovf at step 4.
//  SETTLE: counts SETTLE_CYC cycles, then CMD for step 3.
//  Error: icb_rsp_err=1 at any step sets a sticky error flag.
//   Steps 0-1 error: jump to DONE with no CTRL writes.
//   Steps 2-4 error: jump to step 5 so the adder is disabled.
//   Step 5 error: go to DONE.
//  Timeout: TIMEOUT cycles in RSP without icb_rsp_valid sets the error flag and goes to DONE.
//   The in-flight transaction is abandoned; icb_rsp_ready drops.
//  DONE: res_valid=1. res_err = sticky error flag. If error, res_sum=0 and res_ovf=0.
//   Go to IDLE on res_ready; the error flag clears on that transition.
//  Latency: ideal zero-wait slave with 1-cycle response gives req accept to res_valid = 6*2 + SETTLE_CYC + 1 cycles.
//  Reset (async, any state): FSM=IDLE, step=0, all counters and flags = 0.
//   Outputs: req_ready=1; icb_cmd_valid=0, icb_rsp_ready=0; res_valid=0; res_sum=0, res_ovf=0, res_err=0.
//   icb_cmd_read=0, icb_cmd_addr=0, icb_cmd_wdata=0, icb_cmd_wmask=0.
//   A mid-transaction reset drops the transaction; no completion is generated.
//  Result backpressure: res_valid with res_ready=0 holds all res_* stable; req_ready stays 0.
//  Operand capture: req_* may change after acceptance with no effect on the run in progress.
// TESTING
//  1. augend=5, addend=7, zero-wait slave model -> 6 ICB transactions in map order, res_sum=12, res_ovf=0, res_err=0.
//  2. augend=32'h7FFF_FFFF, addend=1; slave reports OFSIGN=1 -> res_sum=32'h8000_0000, res_ovf=1.
//  3. cmd_ready low 5 cycles at step 1; rsp_valid delayed 3 cycles at step 3 -> cmd fields stable while waiting, same result.
//  4. icb_rsp_err=1 on step 3 -> step 4 skipped; step 5 (CTRL=0) issued; res_err=1, res_sum=0.
//  5. No response at step 0 for TIMEOUT cycles -> DONE with res_err=1, no further commands, rsp_ready=0.
//  6. rst_n low during RSP of step 2, then a new request -> clean restart at step 0. res_ready held 0 in DONE for 10 cycles -> outputs stable.

Source files
------------

// File: rtl/icb_add_master.sv
// ICB initiator for the memory-mapped adder: writes both operands, enables
// the adder, waits a settle period, then reads SUM and OFSIGN and disables it.
module icb_add_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h1004_2000,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_augend,
  input  logic [31:0] req_addend,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_ovf,
  output logic        res_err,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_addr,
  output logic [31:0] icb_cmd_wdata,
  output logic [3:0]  icb_cmd_wmask,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata,
  input  logic        icb_rsp_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RSP, S_SETTLE, S_DONE} state_e;

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  // Command fields for one step of the register sequence
  function automatic cmd_t step_cmd(input logic [2:0] step, input logic [31:0] aug,
                                    input logic [31:0] add);
    cmd_t c;
    c.rd    = 1'b0;
    c.addr  = BASE_ADDR;
    c.wdata = '0;
    c.wmask = 4'hF;
    case (step)
      3'd0: c.wdata = aug;
      3'd1: begin c.addr = BASE_ADDR + 32'h04; c.wdata = add;   end
      3'd2: begin c.addr = BASE_ADDR + 32'h08; c.wdata = 32'd1; end
      3'd3: begin c.addr = BASE_ADDR + 32'h0C; c.rd = 1'b1; c.wmask = '0; end
      3'd4: begin c.addr = BASE_ADDR + 32'h10; c.rd = 1'b1; c.wmask = '0; end
      default: c.addr = BASE_ADDR + 32'h08;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [31:0]      aug_q, aug_d;
  logic [31:0]      add_q, add_d;
  cmd_t             cmd_q, cmd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             err_q, err_d;
  logic [31:0]      sum_q, sum_d;
  logic             ovf_q, ovf_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      aug_q   <= '0;
      add_q   <= '0;
      cmd_q   <= '0;
      tmo_q   <= '0;
      set_q   <= '0;
      err_q   <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      aug_q   <= aug_d;
      add_q   <= add_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
      set_q   <= set_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // Sequencer: next state, step advance, error routing and result capture
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    aug_d   = aug_q;
    add_d   = add_q;
    cmd_d   = cmd_q;
    tmo_d   = tmo_q;
    set_d   = set_q;
    err_d   = err_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          aug_d   = req_augend;
          add_d   = req_addend;
          step_d  = '0;
          err_d   = 1'b0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          cmd_d   = step_cmd(3'd0, req_augend, req_addend);
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (icb_cmd_ready) begin
          tmo_d   = '0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err) begin
            err_d = 1'b1;
            if (step_q <= 3'd1 || step_q == 3'd5) begin
              state_d = S_DONE;
            end else begin
              // adder may already be enabled: still issue the CTRL=0 write
              step_d  = 3'd5;
              cmd_d   = step_cmd(3'd5, aug_q, add_q);
              state_d = S_CMD;
            end
          end else begin
            if (step_q == 3'd3) sum_d = icb_rsp_rdata;
            if (step_q == 3'd4) ovf_d = icb_rsp_rdata[0];
            if (step_q == 3'd2) begin
              set_d   = '0;
              state_d = S_SETTLE;
            end else if (step_q == 3'd5) begin
              state_d = S_DONE;
            end else begin
              step_d  = step_q + 3'd1;
              cmd_d   = step_cmd(step_q + 3'd1, aug_q, add_q);
              state_d = S_CMD;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (set_q == SET_LAST) begin
          step_d  = 3'd3;
          cmd_d   = step_cmd(3'd3, aug_q, add_q);
          state_d = S_CMD;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready     = (state_q == S_IDLE);
  assign icb_cmd_valid = (state_q == S_CMD);
  assign icb_rsp_ready = (state_q == S_RSP);
  assign res_valid     = (state_q == S_DONE);
  assign res_err       = err_q && (state_q == S_DONE);
  assign res_sum       = err_q ? '0 : sum_q;
  assign res_ovf       = err_q ? 1'b0 : ovf_q;
  assign icb_cmd_read  = cmd_q.rd;
  assign icb_cmd_addr  = cmd_q.addr;
  assign icb_cmd_wdata = cmd_q.wdata;
  assign icb_cmd_wmask = cmd_q.wmask;

endmodule

// File: tb/tb_icb_add_master.sv
// Bench for icb_add_master: reactive ICB adder slave, command and result scoreboards.
module tb_icb_add_master;

  localparam logic [31:0] BASE   = 32'h1004_2000;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned TMO    = 64;
  localparam int unsigned NONE   = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_augend, req_addend;
  logic        res_valid, res_ready;
  logic [31:0] res_sum;
  logic        res_ovf, res_err;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  icb_add_master #(
    .BASE_ADDR (BASE),
    .SETTLE_CYC(SETTLE),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_augend   (req_augend),
    .req_addend   (req_addend),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_sum      (res_sum),
    .res_ovf      (res_ovf),
    .res_err      (res_err),
    .icb_cmd_valid(icb_cmd_valid),
    .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read (icb_cmd_read),
    .icb_cmd_addr (icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid),
    .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err  (icb_rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
    logic        err;
  } res_t;

  typedef struct {
    logic [31:0] aug, add, exp_sum;
    logic        exp_ovf, exp_err;
    int unsigned stall_step, stall_cyc, delay_step, delay_cyc;
    int unsigned err_step, noresp_step, exp_lat, hold;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  cmd_t exp_cmd_q[$];
  res_t exp_res_q[$];

  int unsigned cfg_stall_step = NONE, cfg_stall_cyc = 0;
  int unsigned cfg_delay_step = NONE, cfg_delay_cyc = 0;
  int unsigned cfg_err_step = NONE, cfg_noresp_step = NONE;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_cmd(input string name, input cmd_t got, input cmd_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rd=%b addr=%h wdata=%h wmask=%h expected rd=%b addr=%h wdata=%h wmask=%h",
               name, got.rd, got.addr, got.wdata, got.wmask, exp.rd, exp.addr, exp.wdata, exp.wmask);
    end
  endtask

  function automatic cmd_t mk_cmd(input int unsigned s, input logic [31:0] aug, input logic [31:0] add);
    case (s)
      0: return {1'b0, BASE,           aug,   4'hF};
      1: return {1'b0, BASE + 32'h04,  add,   4'hF};
      2: return {1'b0, BASE + 32'h08,  32'd1, 4'hF};
      3: return {1'b1, BASE + 32'h0C,  32'd0, 4'h0};
      4: return {1'b1, BASE + 32'h10,  32'd0, 4'h0};
      default: return {1'b0, BASE + 32'h08, 32'd0, 4'hF};
    endcase
  endfunction

  function automatic int unsigned step_of(input cmd_t c);
    case (c.addr - BASE)
      32'h00: return 0;
      32'h04: return 1;
      32'h08: return c.wdata[0] ? 2 : 5;
      32'h0C: return 3;
      default: return 4;
    endcase
  endfunction

  // Expected command order, including the error and no-response cut-offs
  task automatic push_cmds(input logic [31:0] aug, input logic [31:0] add,
                           input int unsigned err_s, input int unsigned noresp_s);
    int unsigned s = 0;
    for (int k = 0; k < 8; k++) begin
      exp_cmd_q.push_back(mk_cmd(s, aug, add));
      if (s == noresp_s || s == 5) break;
      if (s == err_s) begin
        if (s <= 1) break;
        s = 5;
      end else begin
        s = s + 1;
      end
    end
  endtask

  // Adder slave: checks every command against the expected queue
  logic [31:0] s_aug = '0, s_add = '0;
  initial begin : slave
    cmd_t got, exp;
    int unsigned st;
    logic [31:0] sum;
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b0;
    icb_rsp_rdata = '0;
    icb_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (icb_cmd_valid && rst_n) begin
        got = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask};
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_cmd", 64'(exp_cmd_q.size()), 64'(1));
          exp = got;
        end else begin
          exp = exp_cmd_q.pop_front();
        end
        st = step_of(exp);
        check_cmd("cmd_fields", got, exp);
        if (st == cfg_stall_step) begin
          for (int unsigned i = 0; i < cfg_stall_cyc; i++) begin
            @(negedge clk);
            got = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask};
            check_cmd("cmd_stable", got, exp);
            check("cmd_valid_held", 64'(icb_cmd_valid), 64'(1));
          end
        end
        icb_cmd_ready = 1'b1;
        @(posedge clk);
        #1 icb_cmd_ready = 1'b0;
        if (!exp.rd && st == 0) s_aug = exp.wdata;
        if (!exp.rd && st == 1) s_add = exp.wdata;
        if (st != cfg_noresp_step) begin
          if (st == cfg_delay_step) begin
            for (int unsigned i = 0; i < cfg_delay_cyc; i++) begin
              @(negedge clk);
              check("rsp_wait_cmd_idle", 64'(icb_cmd_valid), 64'(0));
              check("rsp_wait_ready", 64'(icb_rsp_ready), 64'(1));
            end
          end
          @(negedge clk);
          sum = s_aug + s_add;
          icb_rsp_valid = 1'b1;
          icb_rsp_err   = (st == cfg_err_step);
          icb_rsp_rdata = (st == 3) ? sum :
                          (st == 4) ? {31'd0, (s_aug[31] == s_add[31]) && (sum[31] != s_aug[31])} : '0;
          @(posedge clk);
          #1;
          icb_rsp_valid = 1'b0;
          icb_rsp_err   = 1'b0;
          icb_rsp_rdata = '0;
        end
      end
    end
  end

  task automatic set_cfg(input vec_t v);
    cfg_stall_step  = v.stall_step;
    cfg_stall_cyc   = v.stall_cyc;
    cfg_delay_step  = v.delay_step;
    cfg_delay_cyc   = v.delay_cyc;
    cfg_err_step    = v.err_step;
    cfg_noresp_step = v.noresp_step;
  endtask

  // Hand a request over; leaves the bench one ns after the accepting edge
  task automatic issue_req(input logic [31:0] aug, input logic [31:0] add);
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid  = 1'b1;
    req_augend = aug;
    req_addend = add;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_augend = $urandom;
    req_addend = $urandom;
  endtask

  task automatic run_vec(input vec_t v);
    res_t exp;
    int unsigned lat;
    set_cfg(v);
    push_cmds(v.aug, v.add, v.err_step, v.noresp_step);
    exp_res_q.push_back({v.exp_sum, v.exp_ovf, v.exp_err});
    issue_req(v.aug, v.add);
    lat = 1;  // the accepting cycle is cycle 0; lat is the index of the first res_valid cycle
    while (!res_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("res_valid_seen", 64'(res_valid), 64'(1));
    if (res_valid) begin
      exp = exp_res_q.pop_front();
      check("res", {31'd0, res_sum, res_ovf, res_err}, {31'd0, exp});
      if (v.exp_lat != 0) check("latency", 64'(lat), 64'(v.exp_lat));
      check("req_ready_done", 64'(req_ready), 64'(0));
      check("cmds_issued", 64'(exp_cmd_q.size()), 64'(0));
      check("bus_quiet_done", {62'd0, icb_cmd_valid, icb_rsp_ready}, 64'(0));
      for (int unsigned i = 0; i < v.hold; i++) begin
        @(posedge clk);
        #1;
        check("hold_res", {30'd0, res_valid, req_ready, res_sum, res_ovf, res_err},
              {30'd0, 1'b1, 1'b0, exp});
      end
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("back_to_idle", {62'd0, res_valid, req_ready}, 64'(1));
    end
    exp_cmd_q.delete();
    exp_res_q.delete();
    set_cfg('{default: NONE, stall_cyc: 0, delay_cyc: 0});
  endtask

  function automatic vec_t mk_vec(input logic [31:0] aug, add, es, input logic eo, ee,
                                  input int unsigned sst, sc, dst, dc, est, nst, lt, hd);
    vec_t v;
    v.aug = aug; v.add = add; v.exp_sum = es; v.exp_ovf = eo; v.exp_err = ee;
    v.stall_step = sst; v.stall_cyc = sc; v.delay_step = dst; v.delay_cyc = dc;
    v.err_step = est; v.noresp_step = nst; v.exp_lat = lt; v.hold = hd;
    return v;
  endfunction

  vec_t vecs[9];

  initial begin : main
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_augend = '0; req_addend = '0;
    #12;
    check("reset_ctrl", {58'd0, req_ready, icb_cmd_valid, icb_rsp_ready, res_valid, res_ovf, res_err},
          64'h20);
    check("reset_sum", 64'(res_sum), 64'(0));
    check("reset_cmd_a", {31'd0, icb_cmd_read, icb_cmd_addr}, 64'(0));
    check("reset_cmd_d", {28'd0, icb_cmd_wdata, icb_cmd_wmask}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    //                 aug           add           sum           ovf   err   stall  dly   err   nrsp  lat        hold
    vecs[0] = mk_vec(32'd5,        32'd7,        32'd12,       1'b0, 1'b0, NONE,0, NONE,0, NONE, NONE, 15,        0);
    vecs[1] = mk_vec(32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1, 1'b0, NONE,0, NONE,0, NONE, NONE, 15,        2);
    vecs[2] = mk_vec(32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, NONE,0, NONE,0, NONE, NONE, 15,        0);
    vecs[3] = mk_vec(32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b0, NONE,0, NONE,0, NONE, NONE, 15,        0);
    vecs[4] = mk_vec(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1,   5, 3,   3, NONE, NONE, 23,        0);
    vecs[5] = mk_vec(32'd10,       32'd20,       32'd0,        1'b0, 1'b1, NONE,0, NONE,0, 3,    NONE, 0,         0);
    vecs[6] = mk_vec(32'd1,        32'd2,        32'd0,        1'b0, 1'b1, NONE,0, NONE,0, 0,    NONE, 3,         0);
    vecs[7] = mk_vec(32'd3,        32'd4,        32'd0,        1'b0, 1'b1, NONE,0, NONE,0, 5,    NONE, 15,        0);
    vecs[8] = mk_vec(32'd9,        32'd9,        32'd0,        1'b0, 1'b1, NONE,0, NONE,0, NONE, 0,    TMO + 2,   4);
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset while waiting for the CTRL-enable response, then a clean restart
    cfg_noresp_step = 2;
    push_cmds(32'd100, 32'd200, NONE, 2);
    issue_req(32'd100, 32'd200);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_rsp_wait", {62'd0, icb_rsp_ready, icb_cmd_valid}, 64'h2);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_ctrl", {58'd0, req_ready, icb_cmd_valid, icb_rsp_ready, res_valid, res_ovf, res_err},
          64'h20);
    check("midrun_reset_cmd", {31'd0, icb_cmd_read, icb_cmd_addr}, 64'(0));
    check("midrun_reset_data", {28'd0, icb_cmd_wdata, icb_cmd_wmask}, 64'(0));
    check("pre_reset_cmds", 64'(exp_cmd_q.size()), 64'(0));
    cfg_noresp_step = NONE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_completion_after_reset", {62'd0, res_valid, icb_cmd_valid}, 64'(0));
    end
    run_vec(mk_vec(32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0,
                   NONE, 0, NONE, 0, NONE, NONE, 15, 10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
